iob_dbus_split: RTL and testbench

// - Downstream neighbour of the CPU data bus: one IOB master request in, N_SLAVES IOB slave buses out.
// - Decodes the slave index from the top SEL_W address bits and forwards the request to that slave only.
// - Routes rvalid/rdata of that slave back to the master, one outstanding read at a time.
// - A read that gets no response within the timeout window is terminated with an error response.

---
 rtl/iob_dbus_split_pkg.sv | 18 +
 rtl/iob_dbus_split_timer.sv | 24 ++
 rtl/iob_dbus_split.sv | 136 +++++++++++++
 tb/tb_iob_dbus_split.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/iob_dbus_split_pkg.sv
// Shared types and width helpers for the IOB data-bus splitter.
package iob_dbus_split_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_RD = 1'b1
    } state_t;

    // Request word is {valid, addr, wdata, wstrb}; response word is {rdata, rvalid, ready}.
    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_width(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/iob_dbus_split_timer.sv
// Read-timeout counter: cleared when a read is launched, saturates at all-ones and flags done.
module iob_dbus_split_timer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [TIMEOUT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !done) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done = (cnt_q == '1);

endmodule

// File: rtl/iob_dbus_split.sv
// One IOB master to N_SLAVES IOB slaves, selected by the top address bits,
// with a single outstanding read and a timeout that answers with an all-ones error word.
module iob_dbus_split
    import iob_dbus_split_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int N_SLAVES  = 4,
    parameter int SEL_W     = 2,
    parameter int TIMEOUT_W = 8,
    localparam int STRB_W   = DATA_W / 8,
    localparam int REQ_W    = req_width(ADDR_W, DATA_W),
    localparam int RESP_W   = resp_width(DATA_W)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cke_i,
    input  logic [REQ_W-1:0]           m_req_i,
    output logic [RESP_W-1:0]          m_resp_o,
    output logic [N_SLAVES*REQ_W-1:0]  s_req_o,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp_i,
    output logic                       err_o
);

    state_t              state_q;
    logic [SEL_W-1:0]    sel_q;
    logic                bad_rd_q;

    logic                m_valid;
    logic [ADDR_W-1:0]   m_addr;
    logic [STRB_W-1:0]   m_wstrb;
    logic [SEL_W-1:0]    sel;
    logic                sel_ok;
    logic                is_idle;
    logic                is_rd;
    logic                fwd;
    logic                m_ready;
    logic                rd_launch;
    logic                tmo_done;

    logic [N_SLAVES-1:0] s_ready;
    logic [N_SLAVES-1:0] s_rvalid;
    logic [DATA_W-1:0]   s_rdata [N_SLAVES];

    logic                cur_rvalid;
    logic                rvalid;
    logic [DATA_W-1:0]   rdata;

    assign m_valid = m_req_i[REQ_W-1];
    assign m_addr  = m_req_i[REQ_W-2 -: ADDR_W];
    assign m_wstrb = m_req_i[STRB_W-1:0];
    assign sel     = m_addr[ADDR_W-1 -: SEL_W];
    assign sel_ok  = int'(sel) < N_SLAVES;
    assign is_idle = (state_q == IDLE);
    assign is_rd   = (m_wstrb == '0);

    // Requests to an unmapped index are acknowledged locally so the master never stalls.
    assign m_ready   = is_idle && (sel_ok ? s_ready[sel] : 1'b1);
    assign fwd       = m_valid && is_idle && sel_ok;
    assign rd_launch = cke_i && fwd && s_ready[sel] && is_rd;

    for (genvar k = 0; k < N_SLAVES; k++) begin : g_slave
        assign s_ready[k]  = s_resp_i[k*RESP_W];
        assign s_rvalid[k] = s_resp_i[k*RESP_W + 1];
        assign s_rdata[k]  = s_resp_i[k*RESP_W + 2 +: DATA_W];
        assign s_req_o[k*REQ_W +: REQ_W] = {fwd && (sel == SEL_W'(k)), m_req_i[REQ_W-2:0]};
    end

    assign cur_rvalid = s_rvalid[sel_q];

    iob_dbus_split_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .clk  (clk_i),
        .rst  (rst_i),
        .clr  (rd_launch),
        .en   (cke_i && !is_idle && !cur_rvalid),
        .done (tmo_done)
    );

    // A slave answer in the timeout cycle takes priority over the error word.
    always_comb begin
        rvalid = 1'b0;
        rdata  = '0;
        if (bad_rd_q) begin
            rvalid = 1'b1;
            rdata  = '1;
        end else if (!is_idle) begin
            rdata = s_rdata[sel_q];
            if (cur_rvalid) begin
                rvalid = 1'b1;
            end else if (tmo_done) begin
                rvalid = 1'b1;
                rdata  = '1;
            end
        end
    end

    assign m_resp_o = {rdata, rvalid, m_ready};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            bad_rd_q <= 1'b0;
            err_o    <= 1'b0;
        end else if (cke_i) begin
            err_o    <= 1'b0;
            bad_rd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_valid && !sel_ok) begin
                        err_o    <= 1'b1;
                        bad_rd_q <= is_rd;
                    end else if (rd_launch) begin
                        sel_q   <= sel;
                        state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (m_valid) begin
                        err_o <= 1'b1;
                    end
                    if (cur_rvalid) begin
                        state_q <= IDLE;
                    end else if (tmo_done) begin
                        state_q <= IDLE;
                        err_o   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_dbus_split.sv
// Randomized scoreboard bench for iob_dbus_split (3 slaves, so index 3 is unmapped; 4-bit timeout).
module tb_iob_dbus_split;

    localparam int NS     = 3;
    localparam int TW     = 4;
    localparam int TMO    = (1 << TW) - 1;
    localparam int REQ_W  = 1 + 32 + 32 + 4;
    localparam int RESP_W = 32 + 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cke = 1'b1;
    logic [REQ_W-1:0]     m_req = '0;
    logic [RESP_W-1:0]    m_resp;
    logic [NS*REQ_W-1:0]  s_req;
    logic [NS*RESP_W-1:0] s_resp;
    logic                 err;

    logic                 sr_ready  [NS];
    logic                 sr_rvalid [NS];
    logic [31:0]          sr_rdata  [NS];

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t rq[$];
    int   eq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    iob_dbus_split #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .N_SLAVES  (NS),
        .SEL_W     (2),
        .TIMEOUT_W (TW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cke_i    (cke),
        .m_req_i  (m_req),
        .m_resp_o (m_resp),
        .s_req_o  (s_req),
        .s_resp_i (s_resp),
        .err_o    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        s_resp = '0;
        for (int k = 0; k < NS; k++) begin
            s_resp[k*RESP_W +: RESP_W] = {sr_rdata[k], sr_rvalid[k], sr_ready[k]};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NS-1:0] s_valid();
        logic [NS-1:0] v;
        for (int k = 0; k < NS; k++) v[k] = s_req[k*REQ_W + REQ_W-1];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard: every master rvalid must match the oldest expected read result.
    always @(negedge clk) begin
        exp_t e;
        logic exp_err;
        if (m_resp[1]) begin
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", 1, 0);
            end else begin
                e = rq.pop_front();
                chk("rvalid_cycle", cyc, e.cyc);
                chk("rdata", m_resp[RESP_W-1:2], e.data);
            end
        end
        exp_err = 1'b0;
        if (eq.size() > 0 && eq[0] == cyc) begin
            exp_err = 1'b1;
            void'(eq.pop_front());
        end
        if (exp_err || err) chk("err_pulse", err, exp_err);
    end

    // lat: slave answers lat cycles after acceptance (0 = never); hold: cke-low cycles mid-wait.
    task automatic txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic rdy,
                       input int lat, input logic [31:0] rdat, input int stray,
                       input int drop_at, input int hold);
        int   sel, c0, endc, other, last;
        logic ok, rd, exp_rdy, resp;
        sel = int'(addr[31:30]);
        ok  = sel < NS;
        rd  = (wstrb == 4'h0);
        step();
        for (int k = 0; k < NS; k++) sr_ready[k] = 1'($urandom_range(0, 1));
        if (ok) sr_ready[sel] = rdy;
        exp_rdy = ok ? rdy : 1'b1;
        m_req = {1'b1, addr, 32'($urandom()), wstrb};
        c0 = cyc;
        @(negedge clk);
        chk("req_ready", m_resp[0], exp_rdy);
        chk("req_route", s_valid(), ok ? (3'b001 << sel) : 3'b000);
        other = (sel + 1) % NS;
        chk("req_bcast_addr", s_req[other*REQ_W + REQ_W-2 -: 32], addr);
        step();
        m_req[REQ_W-1] = 1'b0;
        if (!ok) begin
            eq.push_back(c0 + 1);
            if (rd) rq.push_back('{c0 + 1, 32'hFFFF_FFFF});
            step();
            step();
            return;
        end
        if (!rdy || !rd) begin
            step();
            return;
        end
        resp = (lat >= 1) && (lat <= TMO + 1);
        endc = resp ? c0 + lat : c0 + TMO + 1 + hold;
        rq.push_back('{endc, resp ? rdat : 32'hFFFF_FFFF});
        for (int c = c0 + 1; c <= endc; c++) begin
            if (c > c0 + 1) step();
            cke = !(c >= c0 + 3 && c < c0 + 3 + hold);
            sr_rvalid[sel] = resp && (c == c0 + lat);
            sr_rdata[sel]  = rdat;
            if (stray >= 0 && stray != sel) sr_rvalid[stray] = (c == c0 + lat);
            m_req[REQ_W-1] = (c == c0 + drop_at);
            if (c == c0 + drop_at) eq.push_back(c + 1);
            @(negedge clk);
            chk("wait_ready", m_resp[0], 1'b0);
            if (c == c0 + drop_at) chk("drop_route", s_valid(), 3'b000);
        end
        if (!resp) eq.push_back(endc + 1);
        last = (c0 + lat + 1 > endc + 2) ? c0 + lat + 1 : endc + 2;
        for (int c = endc + 1; c <= last; c++) begin
            step();
            cke = 1'b1;
            m_req[REQ_W-1] = 1'b0;
            for (int k = 0; k < NS; k++) sr_rvalid[k] = 1'b0;
            if (lat > 0 && c == c0 + lat) sr_rvalid[sel] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          s, lat, stray, drop_at;
        logic [31:0] a;
        logic [3:0]  ws;
        for (int k = 0; k < NS; k++) begin
            sr_ready[k]  = 1'b0;
            sr_rvalid[k] = 1'b0;
            sr_rdata[k]  = '0;
        end
        step();
        step();
        @(negedge clk);
        chk("rst_m_resp", m_resp, '0);
        chk("rst_s_valid", s_valid(), '0);
        chk("rst_err", err, 1'b0);
        step();
        rst = 1'b0;

        // Write to slave 1, read with 3-cycle latency, timeout, coincident answer with stray.
        txn(32'h4000_0010, 4'hF, 1'b1, 0, '0, -1, 0, 0);
        txn(32'h8000_0004, 4'h0, 1'b1, 3, 32'hCAFE_F00D, -1, 0, 0);
        txn(32'h8000_0020, 4'h0, 1'b1, 0, '0, -1, 0, 0);
        txn(32'h0000_0040, 4'h0, 1'b1, TMO + 1, 32'h1234_5678, 1, 0, 0);

        // Reset while a read is outstanding; the late answer must be dropped.
        step();
        sr_ready[0] = 1'b1;
        m_req = {1'b1, 32'h0000_0100, 32'h0, 4'h0};
        step();
        m_req[REQ_W-1] = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wait_ready", m_resp[0], 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_ready", m_resp[0], 1'b1);
        step();
        sr_rvalid[0] = 1'b1;
        sr_rdata[0]  = 32'hDEAD_BEEF;
        step();
        sr_rvalid[0] = 1'b0;
        txn(32'h0000_0200, 4'h0, 1'b1, 2, 32'h0BAD_CAFE, -1, 0, 0);

        // Unmapped index, dropped mid-wait request, clock-enable hold, unready slave.
        txn(32'hC000_0000, 4'h0, 1'b1, 0, '0, -1, 0, 0);
        txn(32'hC000_0008, 4'h3, 1'b1, 0, '0, -1, 0, 0);
        txn(32'h4000_0000, 4'h0, 1'b1, 6, 32'h5555_AAAA, -1, 2, 0);
        txn(32'h8000_0000, 4'h0, 1'b1, 0, '0, -1, 0, 3);
        txn(32'h4000_0000, 4'h0, 1'b0, 2, 32'h1111_2222, -1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            s  = $urandom_range(0, 3);
            a  = {2'(s), 30'($urandom())};
            ws = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            lat = $urandom_range(0, 20);
            stray = ($urandom_range(0, 2) == 0) ? (s + 1) % NS : -1;
            drop_at = (lat >= 3 && $urandom_range(0, 3) == 0) ? 2 : 0;
            txn(a, ws, 1'($urandom_range(0, 3) != 0), lat, $urandom(), stray, drop_at, 0);
        end

        step();
        step();
        step();
        chk("rq_drained", rq.size(), 0);
        chk("err_drained", eq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
